// File: rtl/multicycle_main_controller.sv
// ---------------------------------------------------------------------------
// multicycle_main_controller
//
// Moore-style main control FSM for the multi-cycle RV32I datapath. It
// sequences one instruction at a time over a shared instruction/data memory.
// Supported opcodes are R, I-ALU, LW, JALR, SW, JAL, B and LUI. Memory states
// can optionally stall on a ready handshake. Unsupported opcodes raise a
// one-cycle Illegal pulse. Retired instructions are counted in InstrCount.
//
// Parameters
//   MEM_HANDSHAKE : 1 = memory states wait for MemReady, 0 = MemReady ignored
//   CNT_W         : width of the retired-instruction counter (>= 1)
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   Op[6:0]     in   opcode field from IR (valid from DECODE onward)
//   MemReady    in   memory access completes this cycle
//   BranchTaken in   branch unit result for the current BRANCH cycle
//   PCWrite     out  PC register enable
//   AdrSrc      out  memory address select (0 PC, 1 ALUOut)
//   IRWrite     out  IR / OldPC load enable
//   MemWrite    out  memory write enable
//   RegWrite    out  register file write enable
//   Branch      out  high in BRANCH only
//   ResultSrc   out  result mux (00 ALUOut, 01 MemData, 10 ALUResult, 11 ImmExt)
//   ALUSrcA     out  ALU A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB     out  ALU B select (00 rs2, 01 ImmExt, 10 constant 4)
//   ALUOp       out  ALU decoder mode (00 add, 01 R, 10 I, 11 branch)
//   ImmSrc      out  immediate format, decoded from Op
//   Illegal     out  one-cycle pulse on an unsupported opcode
//   InstrCount  out  retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_main_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             MemReady,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             Branch,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             mem_ready_s;
  logic             count_en_s;
  logic [CNT_W-1:0] count_r;

  // Raw write enables; they are forced low while rst is high.
  logic             pc_write_s;
  logic             ir_write_s;
  logic             mem_write_s;
  logic             reg_write_s;

  // Without the handshake every memory access completes in one cycle.
  assign mem_ready_s = MEM_HANDSHAKE ? MemReady : 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore control outputs; everything defaults to 0.
  always_comb begin
    next_state_s = state_r;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    AdrSrc       = 1'b0;
    Branch       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    Illegal      = 1'b0;
    case (state_r)
      S_FETCH: begin
        // PC+4 goes straight to the PC; gating by ready avoids a partial fetch.
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = mem_ready_s;
        pc_write_s = mem_ready_s;
        if (mem_ready_s) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute OldPC+imm into ALUOut for branch/JAL targets.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_R:         next_state_s = S_EXEC_R;
          OP_I:         next_state_s = S_EXEC_I;
          OP_B:         next_state_s = S_BRANCH;
          OP_JAL:       next_state_s = S_JAL;
          OP_JALR:      next_state_s = S_JALR;
          OP_LUI:       next_state_s = S_LUI;
          default:      next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // Op re-checked here; anything other than LW/SW is treated as illegal.
        case (Op)
          OP_LW:   next_state_s = S_MEM_RD;
          OP_SW:   next_state_s = S_MEM_WR;
          default: next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEM_RD: begin
        AdrSrc = 1'b1;
        if (mem_ready_s) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        ResultSrc    = 2'b01;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WR: begin
        // Write strobe stays up for the whole wait so memory sees a stable request.
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_EXEC_R: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        next_state_s = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ALUOp        = 2'b10;
        next_state_s = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s  = 1'b1;
        ResultSrc    = 2'b00;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b11;
        Branch       = 1'b1;
        pc_write_s   = BranchTaken;
        ResultSrc    = 2'b00;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (target from DECODE) while ALU forms OldPC+4 for rd.
        pc_write_s   = 1'b1;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        next_state_s = S_ALU_WB;
      end
      S_JALR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        next_state_s = S_JALR2;
      end
      S_JALR2: begin
        pc_write_s   = 1'b1;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        next_state_s = S_ALU_WB;
      end
      S_LUI: begin
        ResultSrc    = 2'b11;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ILLEGAL: begin
        Illegal      = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Immediate format decode, independent of state.
  always_comb begin
    ImmSrc = 3'b000;
    case (Op)
      OP_I, OP_LW, OP_JALR: ImmSrc = 3'b000;
      OP_SW:                ImmSrc = 3'b001;
      OP_JAL:               ImmSrc = 3'b010;
      OP_B:                 ImmSrc = 3'b011;
      OP_LUI:               ImmSrc = 3'b100;
      default:              ImmSrc = 3'b000;
    endcase
  end

  // Reset masks every write enable in the same cycle, even mid-access.
  assign PCWrite  = pc_write_s  & ~rst;
  assign IRWrite  = ir_write_s  & ~rst;
  assign MemWrite = mem_write_s & ~rst;
  assign RegWrite = reg_write_s & ~rst;

  // An instruction retires on entry to FETCH, but not from a stall or ILLEGAL.
  assign count_en_s = (next_state_s == S_FETCH) &&
                      (state_r != S_FETCH) &&
                      (state_r != S_ILLEGAL);

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_en_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign InstrCount = count_r;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_controller
//
// Directed bench for multicycle_main_controller. dut uses default parameters;
// dut2 uses CNT_W=2 with MEM_HANDSHAKE=0 and MemReady tied low. Control
// outputs are packed into one 15-bit word and compared every cycle against
// hand-computed per-state values.
// ---------------------------------------------------------------------------
module tb_multicycle_main_controller;

  // ctrl = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, Illegal,
  //         ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0]}
  localparam logic [14:0] C_FETCH   = 15'b1010000_10_00_10_00;
  localparam logic [14:0] C_STALL   = 15'b0000000_10_00_10_00;
  localparam logic [14:0] C_DECODE  = 15'b0000000_00_01_01_00;
  localparam logic [14:0] C_MADDR   = 15'b0000000_00_10_01_00;
  localparam logic [14:0] C_MRD     = 15'b0100000_00_00_00_00;
  localparam logic [14:0] C_MWB     = 15'b0000100_01_00_00_00;
  localparam logic [14:0] C_MWR     = 15'b0101000_00_00_00_00;
  localparam logic [14:0] C_MWR_RST = 15'b0100000_00_00_00_00;
  localparam logic [14:0] C_EXR     = 15'b0000000_00_10_00_01;
  localparam logic [14:0] C_EXI     = 15'b0000000_00_10_01_10;
  localparam logic [14:0] C_ALUWB   = 15'b0000100_00_00_00_00;
  localparam logic [14:0] C_BR_T    = 15'b1000010_00_10_00_11;
  localparam logic [14:0] C_BR_N    = 15'b0000010_00_10_00_11;
  localparam logic [14:0] C_JAL     = 15'b1000000_00_01_10_00;
  localparam logic [14:0] C_LUI     = 15'b0000100_11_00_00_00;
  localparam logic [14:0] C_ILL     = 15'b0000001_00_00_00_00;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst, MemReady, BranchTaken;
  logic [6:0]  Op;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic [31:0] InstrCount;
  logic [14:0] ctrl;

  logic        rst2, MemReady2, BranchTaken2;
  logic [6:0]  Op2;
  logic        PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, Branch2, Illegal2;
  logic [1:0]  ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2;
  logic [2:0]  ImmSrc2;
  logic [1:0]  InstrCount2;
  logic [14:0] ctrl2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign ctrl  = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, Illegal,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  assign ctrl2 = {PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, Branch2, Illegal2,
                  ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2};

  multicycle_main_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .Branch(Branch), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal),
    .InstrCount(InstrCount)
  );

  multicycle_main_controller #(.MEM_HANDSHAKE(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .Op(Op2), .MemReady(MemReady2), .BranchTaken(BranchTaken2),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .IRWrite(IRWrite2), .MemWrite(MemWrite2),
    .RegWrite(RegWrite2), .Branch(Branch2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .ImmSrc(ImmSrc2), .Illegal(Illegal2),
    .InstrCount(InstrCount2)
  );

  task automatic test_reset();
    logic [6:0] ops [0:6];
    logic [2:0] imms [0:6];
    ops[0] = OP_I;   imms[0] = 3'b000;
    ops[1] = OP_LW;  imms[1] = 3'b000;
    ops[2] = OP_SW;  imms[2] = 3'b001;
    ops[3] = OP_JAL; imms[3] = 3'b010;
    ops[4] = OP_B;   imms[4] = 3'b011;
    ops[5] = OP_LUI; imms[5] = 3'b100;
    ops[6] = OP_R;   imms[6] = 3'b000;
    rst = 1'b1; MemReady = 1'b1; BranchTaken = 1'b0; Op = OP_R;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (ctrl !== C_STALL) begin
      $display("FAIL reset_ctrl got %b want %b", ctrl, C_STALL); miscompares++;
    end
    vectors++;
    if (InstrCount !== 32'd0) begin
      $display("FAIL reset_count got %0d want 0", InstrCount); miscompares++;
    end
    for (int i = 0; i < 7; i++) begin
      Op = ops[i]; #1;
      vectors++;
      if (ImmSrc !== imms[i]) begin
        $display("FAIL imm_src op=%b got %b want %b", ops[i], ImmSrc, imms[i]); miscompares++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_r_type();
    logic [14:0] ev [0:3];
    ev[0] = C_FETCH; ev[1] = C_DECODE; ev[2] = C_EXR; ev[3] = C_ALUWB;
    Op = OP_R;
    for (int i = 0; i < 4; i++) begin
      MemReady = 1'b1; #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL r_type cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (InstrCount !== 32'd1) begin
      $display("FAIL r_type_count got %0d want 1", InstrCount); miscompares++;
    end
  endtask

  task automatic test_lw_stall();
    logic [14:0] ev [0:7];
    logic        rv [0:7];
    int          irw, pcw;
    ev[0] = C_STALL; rv[0] = 1'b0;
    ev[1] = C_STALL; rv[1] = 1'b0;
    ev[2] = C_FETCH; rv[2] = 1'b1;
    ev[3] = C_DECODE; rv[3] = 1'b1;
    ev[4] = C_MADDR; rv[4] = 1'b1;
    ev[5] = C_MRD;   rv[5] = 1'b0;
    ev[6] = C_MRD;   rv[6] = 1'b1;
    ev[7] = C_MWB;   rv[7] = 1'b1;
    irw = 0; pcw = 0;
    Op = OP_LW;
    for (int i = 0; i < 8; i++) begin
      MemReady = rv[i];
      if (i == 5) Op = 7'b0000000;  // must not disturb the load in flight
      #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL lw_stall cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      if (IRWrite === 1'b1) irw++;
      if (PCWrite === 1'b1) pcw++;
      @(posedge clk); #1;
    end
    vectors++;
    if (irw !== 1 || pcw !== 1) begin
      $display("FAIL lw_pulses got irw=%0d pcw=%0d want 1 1", irw, pcw); miscompares++;
    end
    vectors++;
    if (InstrCount !== 32'd2) begin
      $display("FAIL lw_count got %0d want 2", InstrCount); miscompares++;
    end
  endtask

  task automatic test_sw_and_i();
    logic [14:0] ev [0:7];
    ev[0] = C_FETCH; ev[1] = C_DECODE; ev[2] = C_MADDR; ev[3] = C_MWR;
    ev[4] = C_FETCH; ev[5] = C_DECODE; ev[6] = C_EXI;   ev[7] = C_ALUWB;
    for (int i = 0; i < 8; i++) begin
      Op = (i < 4) ? OP_SW : OP_I;
      MemReady = 1'b1; #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL sw_i cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (InstrCount !== 32'd4) begin
      $display("FAIL sw_i_count got %0d want 4", InstrCount); miscompares++;
    end
  endtask

  task automatic test_branch();
    logic [14:0] ev [0:5];
    ev[0] = C_FETCH; ev[1] = C_DECODE; ev[2] = C_BR_T;
    ev[3] = C_FETCH; ev[4] = C_DECODE; ev[5] = C_BR_N;
    Op = OP_B;
    for (int i = 0; i < 6; i++) begin
      BranchTaken = (i < 3) ? 1'b1 : 1'b0;
      MemReady = 1'b1; #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL branch cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      @(posedge clk); #1;
    end
    BranchTaken = 1'b0;
    vectors++;
    if (InstrCount !== 32'd6) begin
      $display("FAIL branch_count got %0d want 6", InstrCount); miscompares++;
    end
  endtask

  task automatic test_jumps_lui();
    logic [14:0] ev [0:11];
    logic [6:0]  ov [0:11];
    ev[0] = C_FETCH;  ov[0] = OP_JAL;
    ev[1] = C_DECODE; ov[1] = OP_JAL;
    ev[2] = C_JAL;    ov[2] = OP_JAL;
    ev[3] = C_ALUWB;  ov[3] = OP_JAL;
    ev[4] = C_FETCH;  ov[4] = OP_JALR;
    ev[5] = C_DECODE; ov[5] = OP_JALR;
    ev[6] = C_MADDR;  ov[6] = OP_JALR;
    ev[7] = C_JAL;    ov[7] = OP_JALR;
    ev[8] = C_ALUWB;  ov[8] = OP_JALR;
    ev[9] = C_FETCH;  ov[9] = OP_LUI;
    ev[10] = C_DECODE; ov[10] = OP_LUI;
    ev[11] = C_LUI;   ov[11] = OP_LUI;
    for (int i = 0; i < 12; i++) begin
      Op = ov[i]; MemReady = 1'b1; #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL jumps_lui cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (InstrCount !== 32'd9) begin
      $display("FAIL jumps_lui_count got %0d want 9", InstrCount); miscompares++;
    end
  endtask

  task automatic test_illegal();
    logic [14:0] ev [0:2];
    ev[0] = C_FETCH; ev[1] = C_DECODE; ev[2] = C_ILL;
    Op = 7'b0000000;
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'b1; #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL illegal cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (InstrCount !== 32'd9) begin
      $display("FAIL illegal_count got %0d want 9", InstrCount); miscompares++;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [14:0] ev [0:3];
    logic        rv [0:3];
    ev[0] = C_FETCH;  rv[0] = 1'b1;
    ev[1] = C_DECODE; rv[1] = 1'b1;
    ev[2] = C_MADDR;  rv[2] = 1'b1;
    ev[3] = C_MWR;    rv[3] = 1'b0;
    Op = OP_SW;
    for (int i = 0; i < 4; i++) begin
      MemReady = rv[i]; #1;
      vectors++;
      if (ctrl !== ev[i]) begin
        $display("FAIL store_stall cyc%0d got %b want %b", i, ctrl, ev[i]); miscompares++;
      end
      @(posedge clk); #1;
    end
    MemReady = 1'b0; #1;
    vectors++;
    if (ctrl !== C_MWR) begin
      $display("FAIL store_still_stalled got %b want %b", ctrl, C_MWR); miscompares++;
    end
    rst = 1'b1; #1;
    vectors++;
    if (ctrl !== C_MWR_RST) begin
      $display("FAIL rst_mid_store got %b want %b", ctrl, C_MWR_RST); miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if (ctrl !== C_STALL) begin
      $display("FAIL rst_to_fetch got %b want %b", ctrl, C_STALL); miscompares++;
    end
    vectors++;
    if (InstrCount !== 32'd0) begin
      $display("FAIL rst_count got %0d want 0", InstrCount); miscompares++;
    end
    rst = 1'b0; MemReady = 1'b1; #1;
    vectors++;
    if (ctrl !== C_FETCH) begin
      $display("FAIL post_rst_fetch got %b want %b", ctrl, C_FETCH); miscompares++;
    end
  endtask

  task automatic test_no_handshake_wrap();
    logic [14:0] ev [0:2];
    ev[0] = C_FETCH; ev[1] = C_DECODE; ev[2] = C_LUI;
    Op2 = OP_LUI; MemReady2 = 1'b0;
    rst2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        vectors++;
        if (ctrl2 !== ev[i]) begin
          $display("FAIL nohs lui%0d cyc%0d got %b want %b", k, i, ctrl2, ev[i]); miscompares++;
        end
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (ImmSrc2 !== 3'b100) begin
      $display("FAIL nohs_imm got %b want 100", ImmSrc2); miscompares++;
    end
    vectors++;
    if (InstrCount2 !== 2'd1) begin
      $display("FAIL wrap_count got %0d want 1", InstrCount2); miscompares++;
    end
  endtask

  initial begin
    rst2 = 1'b1; MemReady2 = 1'b0; BranchTaken2 = 1'b0; Op2 = 7'b0000000;
    test_reset();
    test_r_type();
    test_lw_stall();
    test_sw_and_i();
    test_branch();
    test_jumps_lui();
    test_illegal();
    test_reset_mid_store();
    test_no_handshake_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
